// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target block.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_BITS = 8;
    localparam int unsigned I2C_ADDR_W    = 7;
    localparam int unsigned I2C_CNT_W     = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [I2C_CNT_W-1:0] I2C_BIT_MSB = I2C_CNT_W'(I2C_BYTE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_e;

    // Address byte accepted: 7-bit match, and reads only when the read path exists.
    function automatic logic addr_match(input logic [I2C_BYTE_BITS-1:0] addr_byte,
                                        input logic [I2C_ADDR_W-1:0]    dev,
                                        input logic                     read_en);
        return (addr_byte[I2C_BYTE_BITS-1:1] == dev) && (read_en || !addr_byte[0]);
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bus and byte-stream signals between the I2C target and its surroundings.
interface i2c_target_if;
    import i2c_pkg::*;

    logic                     scl_i;
    logic                     sda_i;
    logic                     sda_oe;
    logic [I2C_BYTE_BITS-1:0] rx_data;
    logic                     rx_valid;
    logic                     rx_first;
    logic [I2C_BYTE_BITS-1:0] tx_data;
    logic                     tx_req;
    logic                     busy;

    modport slave (
        input  scl_i, sda_i, tx_data,
        output sda_oe, rx_data, rx_valid, rx_first, tx_req, busy
    );

    modport master (
        output scl_i, sda_i, tx_data,
        input  sda_oe, rx_data, rx_valid, rx_first, tx_req, busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and derives SCL edge strobes plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;

    // Idle bus level is high, so everything resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda      <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_raw};
            sda_sync <= {sda_sync[0], sda_raw};
            scl_q    <= scl_sync[1];
            sda      <= sda_sync[1];
        end
    end

    assign scl_rise_c = scl_sync[1] & ~scl_q;
    assign scl_fall_c = ~scl_sync[1] & scl_q;
    assign start_c    = scl_sync[1] & scl_q & sda & ~sda_sync[1];
    assign stop_c     = scl_sync[1] & scl_q & ~sda & sda_sync[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write bytes out on rx_*, read bytes in via tx_*.
// Define I2C_TARGET_READ_EN to build the read path (READ/READ_ACK, tx_req).
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h50
) (
    input  logic         clk,
    input  logic         reset,
    i2c_target_if.slave  bus
);

`ifdef I2C_TARGET_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
    logic unused_tx;
    assign unused_tx = ^bus.tx_data;
`endif

    logic sda, scl_rise_c, scl_fall_c, start_c, stop_c;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_raw    (bus.scl_i),
        .sda_raw    (bus.sda_i),
        .sda        (sda),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    i2c_state_e               state, state_n;
    logic [I2C_CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [I2C_BYTE_BITS-1:0] shreg, shreg_n, tx_shreg, tx_shreg_n;
    logic [I2C_BYTE_BITS-1:0] rx_data_q, rx_data_n;
    logic [I2C_BYTE_BITS-1:0] shift_in;
    logic armed, armed_n, rw, rw_n, first_pend, first_n;
    logic sda_oe_q, sda_oe_n, busy_q, busy_n;
    logic rx_valid_q, rx_valid_n, rx_first_q, rx_first_n, tx_req_q, tx_req_n;

    assign shift_in = {shreg[I2C_BYTE_BITS-2:0], sda};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= I2C_BIT_MSB;
            shreg      <= '0;
            tx_shreg   <= '0;
            rx_data_q  <= '0;
            armed      <= 1'b0;
            rw         <= 1'b0;
            first_pend <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            tx_shreg   <= tx_shreg_n;
            rx_data_q  <= rx_data_n;
            armed      <= armed_n;
            rw         <= rw_n;
            first_pend <= first_n;
            sda_oe_q   <= sda_oe_n;
            busy_q     <= busy_n;
            rx_valid_q <= rx_valid_n;
            rx_first_q <= rx_first_n;
            tx_req_q   <= tx_req_n;
        end
    end

    // armed: the 8th bit (or the master's ACK) has been sampled; the next SCL fall ends the slot.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        tx_shreg_n = tx_shreg;
        rx_data_n  = rx_data_q;
        armed_n    = armed;
        rw_n       = rw;
        first_n    = first_pend;
        sda_oe_n   = sda_oe_q;
        busy_n     = busy_q;
        rx_valid_n = 1'b0;
        rx_first_n = 1'b0;
        tx_req_n   = 1'b0;

        if (stop_c) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            armed_n  = 1'b0;
        end else if (start_c) begin
            state_n   = ADDR;
            bit_cnt_n = I2C_BIT_MSB;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            armed_n   = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise_c) begin
                        shreg_n = shift_in;
                        if (bit_cnt == '0) armed_n = 1'b1;
                        else               bit_cnt_n = bit_cnt - I2C_CNT_W'(1);
                    end else if (scl_fall_c && armed) begin
                        armed_n   = 1'b0;
                        bit_cnt_n = I2C_BIT_MSB;
                        if (addr_match(shreg, DEV_ADDR, READ_EN)) begin
                            state_n  = ADDR_ACK;
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                            rw_n     = shreg[0];
                            first_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = I2C_BIT_MSB;
`ifdef I2C_TARGET_READ_EN
                        if (rw) begin
                            state_n  = READ;
                            tx_req_n = 1'b1;
                        end else begin
                            state_n = WRITE;
                        end
`else
                        state_n = WRITE;
`endif
                    end
                end
                WRITE: begin
                    if (scl_rise_c) begin
                        shreg_n = shift_in;
                        if (bit_cnt == '0) begin
                            armed_n    = 1'b1;
                            rx_data_n  = shift_in;
                            rx_valid_n = 1'b1;
                            rx_first_n = first_pend;
                            first_n    = 1'b0;
                        end else begin
                            bit_cnt_n = bit_cnt - I2C_CNT_W'(1);
                        end
                    end else if (scl_fall_c && armed) begin
                        armed_n  = 1'b0;
                        state_n  = WRITE_ACK;
                        sda_oe_n = 1'b1;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall_c) begin
                        state_n   = WRITE;
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = I2C_BIT_MSB;
                    end
                end
`ifdef I2C_TARGET_READ_EN
                READ: begin
                    // The first bit is driven in the tx_req cycle, while SCL is still low.
                    if (tx_req_q) begin
                        tx_shreg_n = bus.tx_data;
                        sda_oe_n   = ~bus.tx_data[I2C_BYTE_BITS-1];
                    end else if (scl_fall_c) begin
                        if (bit_cnt == '0) begin
                            state_n  = READ_ACK;
                            sda_oe_n = 1'b0;
                        end else begin
                            bit_cnt_n  = bit_cnt - I2C_CNT_W'(1);
                            tx_shreg_n = {tx_shreg[I2C_BYTE_BITS-2:0], 1'b0};
                            sda_oe_n   = ~tx_shreg[I2C_BYTE_BITS-2];
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise_c) begin
                        if (sda == I2C_NACK) begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end else begin
                            armed_n = 1'b1;
                        end
                    end else if (scl_fall_c && armed) begin
                        armed_n   = 1'b0;
                        state_n   = READ;
                        bit_cnt_n = I2C_BIT_MSB;
                        tx_req_n  = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.busy     = busy_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_first = rx_first_q;
    assign bus.tx_req   = tx_req_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master, directed scenarios and random transfers vs a transaction model.
`timescale 1ns/1ps
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int unsigned Q   = 8;      // clk cycles per quarter SCL period
    localparam logic [6:0]  DEV = 7'h50;
`ifdef I2C_TARGET_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_target_if bus();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_target #(.DEV_ADDR(DEV)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Passive monitor, sampled away from the active edge.
    logic [8:0]  rx_log [$];
    int unsigned tx_req_cnt = 0, oe_cnt = 0, busy_cnt = 0, stray_first = 0;
    always @(negedge clk) begin
        if (bus.rx_valid) rx_log.push_back({bus.rx_first, bus.rx_data});
        if (bus.rx_first && !bus.rx_valid) stray_first++;
        if (bus.tx_req) tx_req_cnt++;
        if (bus.sda_oe) oe_cnt++;
        if (bus.busy) busy_cnt++;
    end

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = bus.sda_i; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    logic [7:0] pay [4];

    // One transaction: the model decides ACKs, delivered bytes and tx_req count from address/rw/payload.
    task automatic run_xfer(input logic [6:0] addr, input logic rw, input int n, input bit do_stop);
        logic       ack;
        logic [7:0] b;
        bit         match;
        int         rx0;
        int unsigned tx0;
        match = (addr == DEV) && (!rw || READ_EN);
        rx0 = rx_log.size();
        tx0 = tx_req_cnt;
        bus.tx_data = pay[0];
        i2c_start();
        send_byte({addr, rw}, ack);
        check_eq("addr_ack", 32'(ack), 32'(match ? I2C_ACK : I2C_NACK));
        @(negedge clk);
        check_eq("busy_after_addr", 32'(bus.busy), 32'(match));
        if (match && !rw) begin
            for (int k = 0; k < n; k++) begin
                send_byte(pay[k], ack);
                check_eq("data_ack", 32'(ack), 32'(I2C_ACK));
            end
            @(negedge clk);
            check_eq("busy_in_write", 32'(bus.busy), 32'd1);
        end else if (match) begin
            for (int k = 0; k < n; k++) begin
                for (int i = 7; i >= 0; i--) begin
                    read_bit(ack);
                    b[i] = ack;
                end
                if (k + 1 < n) bus.tx_data = pay[k + 1];
                write_bit((k == n - 1) ? I2C_NACK : I2C_ACK);
                check_eq("read_byte", 32'(b), 32'(pay[k]));
            end
            @(negedge clk);
            check_eq("busy_after_nack", 32'(bus.busy), 32'd0);
        end
        check_eq("rx_count", 32'(rx_log.size() - rx0), 32'((match && !rw) ? n : 0));
        if (match && !rw) begin
            for (int k = 0; k < n && rx0 + k < rx_log.size(); k++)
                check_eq("rx_byte", 32'(rx_log[rx0 + k]), 32'({(k == 0), pay[k]}));
        end
        check_eq("tx_req_count", 32'(tx_req_cnt - tx0), 32'((match && rw) ? n : 0));
        if (do_stop) begin
            i2c_stop();
            @(negedge clk);
            check_eq("busy_after_stop", 32'(bus.busy), 32'd0);
            check_eq("oe_after_stop", 32'(bus.sda_oe), 32'd0);
        end
    endtask

    initial begin
        int          rx0;
        int unsigned oe0, busy0;
        logic        ack;

        bus.tx_data = 8'h00;
        wait_clk(4);
        @(negedge clk);
        check_eq("reset_sda_oe",   32'(bus.sda_oe),   32'd0);
        check_eq("reset_busy",     32'(bus.busy),     32'd0);
        check_eq("reset_rx_data",  32'(bus.rx_data),  32'd0);
        check_eq("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("reset_tx_req",   32'(bus.tx_req),   32'd0);
        reset = 1'b0;
        wait_clk(4);

        // Single write byte, then two bytes.
        pay[0] = 8'hAA;
        run_xfer(DEV, 1'b0, 1, 1'b1);
        pay[0] = 8'h11; pay[1] = 8'h22;
        run_xfer(DEV, 1'b0, 2, 1'b1);

        // Foreign address: bus must stay untouched.
        oe0 = oe_cnt; busy0 = busy_cnt;
        pay[0] = 8'h77;
        run_xfer(7'h51, 1'b0, 1, 1'b1);
        check_eq("foreign_oe_cycles",   32'(oe_cnt - oe0),     32'd0);
        check_eq("foreign_busy_cycles", 32'(busy_cnt - busy0), 32'd0);

        // Read of 0x5A with master NACK (NACKed address without the read path).
        pay[0] = 8'h5A;
        run_xfer(DEV, 1'b1, 1, 1'b1);

        // Partial byte aborted by repeated START.
        rx0 = rx_log.size();
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        check_eq("partial_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 4; i++) write_bit(1'(i & 1));
        pay[0] = 8'h33;
        run_xfer(DEV, 1'b0, 1, 1'b1);
        check_eq("partial_rx_total", 32'(rx_log.size() - rx0), 32'd1);
        check_eq("rx_data_33", 32'(bus.rx_data), 32'h33);

        // Reset mid address byte, remaining clocks ignored, next transfer normal.
        i2c_start();
        for (int i = 0; i < 4; i++) write_bit(1'(i == 1));
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_sda_oe",  32'(bus.sda_oe),  32'd0);
        check_eq("midrst_busy",    32'(bus.busy),    32'd0);
        check_eq("midrst_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("midrst_rx_first", 32'(bus.rx_first), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        read_bit(ack);
        check_eq("midrst_ignored_ack", 32'(ack), 32'(I2C_NACK));
        i2c_stop();
        pay[0] = 8'h5C;
        run_xfer(DEV, 1'b0, 1, 1'b1);

        // Random transactions, some chained by repeated START.
        for (int t = 0; t < 16; t++) begin
            logic [6:0] a;
            int         n;
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : DEV;
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) pay[k] = 8'($urandom);
            run_xfer(a, 1'($urandom_range(0, 1)), n, (t == 15) || ($urandom_range(0, 1) == 1));
        end

        check_eq("rx_first_without_valid", 32'(stray_first), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
